// File: rtl/masked_sbox_lane_pipe_if.sv
// Beat interface of the masked S-box pipeline: two input shares, per-lane randomness,
// two result shares plus occupancy. No backpressure in either direction.
interface masked_sbox_lane_pipe_if #(
    parameter int LANES  = 1,
    parameter int RAND_W = 2048
) ();
    logic                    in_valid;
    logic                    mode;
    logic [8*LANES-1:0]      in0;
    logic [8*LANES-1:0]      in1;
    logic [RAND_W*LANES-1:0] r;
    logic                    out_valid;
    logic                    out_mode;
    logic [8*LANES-1:0]      out0;
    logic [8*LANES-1:0]      out1;
    logic [2:0]              inflight;

    modport master (
        output in_valid, mode, in0, in1, r,
        input  out_valid, out_mode, out0, out1, inflight
    );

    modport slave (
        input  in_valid, mode, in0, in1, r,
        output out_valid, out_mode, out0, out1, inflight
    );
endinterface

// File: rtl/masked_sbox_lane_pipe.sv
// Two-share masked AES S-box / inverse S-box, LANES byte lanes per beat, one beat per cycle.
// Optional MASKED_SBOX_OUT_REG_EN adds a registered output stage (latency GADGET_LAT+1).
module masked_sbox_lane_pipe #(
    parameter int LANES      = 1,
    parameter int RAND_W     = 2048,
    parameter int GADGET_LAT = 2
) (
    input logic clk,
    input logic rst,
    masked_sbox_lane_pipe_if.slave bus
);
`ifdef MASKED_SBOX_OUT_REG_EN
    localparam int L = GADGET_LAT + 1;
`else
    localparam int L = GADGET_LAT;
`endif
    localparam int NTAB = 256;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^-1 in GF(2^8), with 0 mapping to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] acc;
        p   = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] fwd_lin(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
    endfunction

    function automatic logic [7:0] inv_lin(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]};
    endfunction

    logic [L:1]            vld_pipe;
    logic [L:1]            mode_pipe;
    logic [2:0]            inflight_q;
    logic [LANES-1:0][7:0] res0;
    logic [LANES-1:0][7:0] res1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe   <= '0;
            mode_pipe  <= '0;
            inflight_q <= '0;
        end else begin
            vld_pipe[1]  <= bus.in_valid;
            mode_pipe[1] <= bus.mode;
            for (int i = 2; i <= L; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                mode_pipe[i] <= mode_pipe[i-1];
            end
            inflight_q <= inflight_q + 3'(bus.in_valid) - 3'(vld_pipe[L]);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] a0, a1, sel_q, m0, m1, g0, g1, h0, h1;
        logic [7:0] tab [NTAB];
        logic [7:0] msk [NTAB];

        // Inverse affine before the gadget; its constant only touches share 0
        assign a0 = bus.mode ? (inv_lin(bus.in0[8*k +: 8]) ^ 8'h05) : bus.in0[8*k +: 8];
        assign a1 = bus.mode ? inv_lin(bus.in1[8*k +: 8]) : bus.in1[8*k +: 8];

        // Gadget stage 1: every candidate value of share 1 gets its own masked table
        // entry computed from share 0 alone; share 1 only selects after the register.
        always_ff @(posedge clk) begin
            sel_q <= a1;
            for (int j = 0; j < NTAB; j++) begin
                msk[j] <= bus.r[RAND_W*k + 8*j +: 8];
                tab[j] <= gf_inv(a0 ^ 8'(j)) ^ bus.r[RAND_W*k + 8*j +: 8];
            end
        end

        assign m0 = msk[sel_q];
        assign m1 = tab[sel_q];

        if (GADGET_LAT > 1) begin : g_dly
            logic [7:0] q0 [GADGET_LAT-1];
            logic [7:0] q1 [GADGET_LAT-1];
            always_ff @(posedge clk) begin
                q0[0] <= m0;
                q1[0] <= m1;
                for (int i = 1; i < GADGET_LAT - 1; i++) begin
                    q0[i] <= q0[i-1];
                    q1[i] <= q1[i-1];
                end
            end
            assign g0 = q0[GADGET_LAT-2];
            assign g1 = q1[GADGET_LAT-2];
        end else begin : g_nodly
            assign g0 = m0;
            assign g1 = m1;
        end

        assign h0 = mode_pipe[GADGET_LAT] ? g0 : (fwd_lin(g0) ^ 8'h63);
        assign h1 = mode_pipe[GADGET_LAT] ? g1 : fwd_lin(g1);

`ifdef MASKED_SBOX_OUT_REG_EN
        logic [7:0] o0, o1;
        always_ff @(posedge clk) begin
            o0 <= h0;
            o1 <= h1;
        end
        assign res0[k] = o0;
        assign res1[k] = o1;
`else
        assign res0[k] = h0;
        assign res1[k] = h1;
`endif
    end

    // Data registers are unreset; the valid bit hides them, per share
    assign bus.out_valid = vld_pipe[L];
    assign bus.out_mode  = vld_pipe[L] & mode_pipe[L];
    assign bus.out0      = vld_pipe[L] ? res0 : '0;
    assign bus.out1      = vld_pipe[L] ? res1 : '0;
    assign bus.inflight  = inflight_q;
endmodule

// File: tb/tb_masked_sbox_lane_pipe.sv
// Directed bench for masked_sbox_lane_pipe: a 1-lane and a 4-lane instance, random share
// splits and randomness, hand-computed FIPS-197 results, latency/occupancy/reset checks.
module tb_masked_sbox_lane_pipe;
    localparam int GL = 2;
    localparam int RW = 2048;
`ifdef MASKED_SBOX_OUT_REG_EN
    localparam int L = GL + 1;
`else
    localparam int L = GL;
`endif

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    logic        sv [16];
    logic        sm [16];
    logic [31:0] sx [16];
    logic [31:0] sy [16];
    int          sn;

    masked_sbox_lane_pipe_if #(.LANES(1), .RAND_W(RW)) b1 ();
    masked_sbox_lane_pipe_if #(.LANES(4), .RAND_W(RW)) b4 ();

    masked_sbox_lane_pipe #(.LANES(1), .RAND_W(RW), .GADGET_LAT(GL)) u_dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );
    masked_sbox_lane_pipe #(.LANES(4), .RAND_W(RW), .GADGET_LAT(GL)) u_dut4 (
        .clk(clk), .rst(rst), .bus(b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic m, input logic [7:0] s0, input logic [7:0] s1);
        b1.in_valid = v;
        b1.mode     = m;
        b1.in0      = s0;
        b1.in1      = s1;
        for (int i = 0; i < RW / 32; i++) b1.r[32*i +: 32] = $urandom;
    endtask

    // Random share split of x across all four lanes
    task automatic drive4(input logic v, input logic m, input logic [31:0] x);
        logic [31:0] s;
        s = $urandom;
        b4.in_valid = v;
        b4.mode     = m;
        b4.in0      = x ^ s;
        b4.in1      = s;
        for (int i = 0; i < 4 * RW / 32; i++) b4.r[32*i +: 32] = $urandom;
    endtask

    task automatic put(input logic v, input logic m, input logic [31:0] x, input logic [31:0] y);
        sv[sn] = v;
        sm[sn] = m;
        sx[sn] = x;
        sy[sn] = y;
        sn++;
    endtask

    // Beat c is driven in cycle c; its result is due in cycle c+L, and inflight in
    // cycle c counts the valid beats driven in cycles c-L .. c-1.
    task automatic run_stream(input string tag);
        int exp_inf;
        for (int c = 0; c < sn + L + 1; c++) begin
            exp_inf = 0;
            for (int k = c - L; k < c; k++)
                if (k >= 0 && k < sn && sv[k]) exp_inf++;
            if (c >= L && c - L < sn && sv[c-L]) begin
                chk({tag, "_vld"}, 32'(b4.out_valid), 32'd1);
                chk({tag, "_y"}, b4.out0 ^ b4.out1, sy[c-L]);
                chk({tag, "_mode"}, 32'(b4.out_mode), 32'(sm[c-L]));
            end else begin
                chk({tag, "_vld"}, 32'(b4.out_valid), 32'd0);
                chk({tag, "_gate"}, b4.out0 | b4.out1, 32'd0);
                chk({tag, "_mode"}, 32'(b4.out_mode), 32'd0);
            end
            chk({tag, "_inflight"}, 32'(b4.inflight), 32'(exp_inf));
            if (c < sn) drive4(sv[c], sm[c], sx[c]);
            else        drive4(1'b0, 1'b0, 32'h0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive1(1'b0, 1'b0, 8'h00, 8'h00);
        drive4(1'b0, 1'b0, 32'h0);
        repeat (2) tick();
        chk("rst_vld", 32'(b4.out_valid), 32'd0);
        chk("rst_mode", 32'(b4.out_mode), 32'd0);
        chk("rst_out", b4.out0 | b4.out1, 32'd0);
        chk("rst_inflight", 32'(b4.inflight), 32'd0);
        chk("rst_vld1", 32'(b1.out_valid), 32'd0);
        chk("rst_inflight1", 32'(b1.inflight), 32'd0);
        rst = 1'b0;

        // 1-lane: x = 0xA5 ^ 0xA5 = 0 -> 0x63
        drive1(1'b1, 1'b0, 8'hA5, 8'hA5);
        repeat (L - 1) begin
            tick();
            drive1(1'b0, 1'b0, 8'h00, 8'h00);
        end
        chk("l1_early", 32'(b1.out_valid), 32'd0);
        tick();
        drive1(1'b0, 1'b0, 8'h00, 8'h00);
        chk("l1_vld", 32'(b1.out_valid), 32'd1);
        chk("l1_y", 32'(b1.out0 ^ b1.out1), 32'h63);
        tick();
        chk("l1_after", 32'(b1.out_valid), 32'd0);
        chk("l1_inflight", 32'(b1.inflight), 32'd0);

        // forward, 4 lanes: 53,00,01,FF -> ED,63,7C,16
        sn = 0;
        put(1'b1, 1'b0, 32'h530001FF, 32'hED637C16);
        run_stream("fwd4");

        // inverse, back-to-back
        sn = 0;
        put(1'b1, 1'b1, 32'hED7C16ED, 32'h5301FF53);
        put(1'b1, 1'b1, 32'h63636363, 32'h00000000);
        run_stream("inv4");

        // valid pattern 1,0,1,1 with mixed modes
        sn = 0;
        put(1'b1, 1'b0, 32'h10101010, 32'hCACACACA);
        put(1'b0, 1'b0, 32'hDEADBEEF, 32'h00000000);
        put(1'b1, 1'b1, 32'h7C167C16, 32'h01FF01FF);
        put(1'b1, 1'b0, 32'h0053FF01, 32'h63ED167C);
        run_stream("bubble");

        // reset mid-flight discards both beats
        drive4(1'b1, 1'b0, 32'h53535353);
        tick();
        drive4(1'b1, 1'b1, 32'h63636363);
        tick();
        drive4(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        chk("midrst_vld", 32'(b4.out_valid), 32'd0);
        chk("midrst_inflight", 32'(b4.inflight), 32'd0);
        chk("midrst_out", b4.out0 | b4.out1, 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < L + 2; c++) begin
            chk("postrst_vld", 32'(b4.out_valid), 32'd0);
            chk("postrst_inflight", 32'(b4.inflight), 32'd0);
            tick();
        end

        // beat in the very first cycle after reset release
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sn = 0;
        put(1'b1, 1'b0, 32'h00000053, 32'h636363ED);
        put(1'b1, 1'b1, 32'h6363ED7C, 32'h00005301);
        run_stream("first");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/masked_sbox_lane_pipe.md
MASKED_SBOX_LANE_PIPE -- requirements
Module: masked_sbox_lane_pipe

Interface
REQ-001 SHALL have parameter LANES, default 1, giving the number of byte lanes processed per beat (1..4).
REQ-002 SHALL have parameter RAND_W, default 2048, giving the fresh-randomness bits consumed per lane per beat.
REQ-003 SHALL have parameter GADGET_LAT, default 2, set equal to the clock latency of the team's GHPC inversion gadget in low-latency pipelined configuration.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: the beat on in0/in1/mode is valid this cycle.
REQ-007 SHALL have port mode, input, 1 bit: 0 selects the forward S-box; 1 selects the inverse S-box.
REQ-008 SHALL have port in0, input, 8*LANES bits: share 0, with lane k at bits [8k+7:8k].
REQ-009 SHALL have port in1, input, 8*LANES bits: share 1, with the same lane packing.
REQ-010 SHALL have port r, input, RAND_W*LANES bits: fresh randomness, with lane k at [RAND_W*(k+1)-1:RAND_W*k].
REQ-011 SHALL have port out_valid, output, 1 bit: out0/out1 hold a result.
REQ-012 SHALL have port out_mode, output, 1 bit: the mode of the beat currently on the output.
REQ-013 SHALL have port out0, output, 8*LANES bits: result share 0.
REQ-014 SHALL have port out1, output, 8*LANES bits: result share 1.
REQ-015 SHALL have port inflight, output, 3 bits: count of valid beats inside the pipeline.

Function
REQ-016 SHALL define, per lane, the unmasked value x as in0 XOR in1 and the unmasked result y as out0 XOR out1.
REQ-017 SHALL produce y = SBOX(x) when mode=0 and y = INV_SBOX(x) when mode=1, per FIPS-197.
REQ-018 SHALL, for mode=0, apply the GF(2^8) inversion gadget first and then the forward affine map.
- The linear part applies to both shares.
- The constant 0x63 applies to share 0 only.
REQ-019 SHALL, for mode=1, apply the inverse affine map to the input shares before the gadget.
- The linear part applies to both shares.
- The constant 0x05 applies to share 0 only.
- The gadget output then passes through unchanged.
REQ-020 SHALL never combine share 0 and share 1 in any logic outside the gadget.
REQ-021 SHALL have a total latency L = GADGET_LAT (see REQ-033 for the macro case): a beat presented at cycle t appears with out_valid=1 at cycle t+L.
REQ-022 SHALL accept one beat per cycle; there is no backpressure and in_valid is never refused.
REQ-023 SHALL carry in_valid and mode through an L-deep shift register aligned with the gadget pipeline.
REQ-024 SHALL sample r in the same cycle as the beat; r values in cycles with in_valid=0 are don't-care.
REQ-025 SHALL update inflight each cycle as inflight + in_valid - out_valid.
- Simultaneous entry and exit leave inflight unchanged.
- inflight never exceeds L.
REQ-026 SHALL force out0, out1 and out_mode to 0 while out_valid=0, gating each share separately.
REQ-027 SHALL treat bubbles (in_valid=0 between valid beats) as follows:
- each bubble yields out_valid=0 exactly L cycles later;
- neighbouring results are not affected.

Reset
REQ-028 SHALL, while rst=1, asynchronously clear the valid/mode shift register and inflight.
REQ-029 SHALL drive out_valid=0, out_mode=0, out0=out1=0 and inflight=0 during reset.
REQ-030 SHALL leave share datapath registers unreset; they are masked by REQ-026.
REQ-031 SHALL discard beats in flight when reset is asserted mid-operation; none of them appears after rst deasserts.
REQ-032 SHALL accept a beat in the first cycle after rst deasserts; its result appears L cycles later.

Configuration
REQ-033 SHALL support macro MASKED_SBOX_OUT_REG_EN.
- Defined: adds a registered output stage on out0/out1/out_mode/out_valid, so L = GADGET_LAT+1 and inflight counts that stage.
- Undefined: outputs are taken directly from the gadget and affine logic, and L = GADGET_LAT.

Verification
REQ-034 SHALL cover: LANES=1, mode=0, in0=0xA5, in1=0xA5 (x=0x00) -> after L cycles out_valid=1 and out0^out1=0x63.
REQ-035 SHALL cover: LANES=4, mode=0, lanes x={0x53,0x00,0x01,0xFF}, random share splits -> y={0xED,0x63,0x7C,0x16}.
REQ-036 SHALL cover: mode=1, x=0xED then x=0x63 on consecutive cycles -> y=0x53 then y=0x00 in consecutive cycles with out_mode=1.
REQ-037 SHALL cover: in_valid pattern 1,0,1,1 -> out_valid pattern 1,0,1,1 starting at cycle L, with inflight peaking at 2 (L=2) and returning to 0.
REQ-038 SHALL cover: rst pulsed one cycle after two valid beats -> out_valid stays 0 and inflight=0 until a new beat, whose result appears L cycles after entry.
REQ-039 SHALL cover: with and without MASKED_SBOX_OUT_REG_EN, x=0x53 -> y=0xED at cycle GADGET_LAT+1 and GADGET_LAT respectively.
